rat_int_ctrl: RTL and testbench

- Interrupt controller for the RAT MCU.
- Synchronizes and debounces the external interrupt line and keeps a pending request.
- Requests service from the control unit, holds the interrupt-enable (I) flag, and drives the save/restore side of the Flags shadow interface:
  - flg_shad_ld pulse on entry.
  - flg_ld_sel restore select on RETI.

---
 rtl/rat_int_pkg.sv | 21 ++
 rtl/int_debounce.sv | 52 +++++
 rtl/rat_int_ctrl.sv | 120 ++++++++++++
 tb/tb_rat_int_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rat_int_pkg.sv
// -----------------------------------------------------------------------------
// rat_int_pkg
// Shared types and constants for the RAT MCU interrupt controller.
//   int_state_t    : interrupt-sequencing FSM states
//   RAT_VEC_W      : program-counter width
//   RAT_INT_VECTOR : address of the interrupt service routine
// -----------------------------------------------------------------------------
package rat_int_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ     = 3'd1,
      SAVE    = 3'd2,
      SERVICE = 3'd3,
      RESTORE = 3'd4
   } int_state_t;

   localparam int RAT_VEC_W = 10;
   localparam logic [RAT_VEC_W-1:0] RAT_INT_VECTOR = 10'h3FF;

endpackage : rat_int_pkg

// File: rtl/int_debounce.sv
// -----------------------------------------------------------------------------
// int_debounce
// Two-flop synchronizer, saturating high-time counter and rising-edge detect
// for an asynchronous interrupt line. A level held high for DEB_CYCLES
// synchronized cycles yields exactly one edge_pulse, however long it stays high.
//   clk        in  system clock, rising edge
//   rst_n      in  asynchronous active-low reset
//   din        in  raw asynchronous input
//   edge_pulse out one-cycle pulse when the debounced level rises
// -----------------------------------------------------------------------------
module int_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic edge_pulse
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] count;
   logic          deb;
   logic          deb_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would collapse the synchronizer chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         count <= '0;
         deb_q <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         // Any low synchronized sample restarts the qualification window.
         if (!sync2)
            count <= '0;
         else if (count != CNT_MAX)
            count <= count + CW'(1);
         deb_q <= deb;
      end
   end

   assign deb        = (count == CNT_MAX);
   assign edge_pulse = deb & ~deb_q;

endmodule : int_debounce

// File: rtl/rat_int_ctrl.sv
// -----------------------------------------------------------------------------
// rat_int_ctrl
// Interrupt controller for the RAT MCU. Debounces the external interrupt,
// keeps a pending request, holds the interrupt-enable flag and sequences
// request / flag save / service / flag restore with the control unit.
//   clk         in  system clock, rising edge
//   rst_n       in  asynchronous active-low reset
//   intr        in  raw external interrupt (asynchronous)
//   i_set       in  SEI executed
//   i_clr       in  CLI executed (wins over i_set)
//   int_ack     in  control unit committed to the interrupt cycle
//   reti        in  RETID/RETIE executed, one-cycle pulse
//   reti_en     in  1 = RETIE, 0 = RETID
//   int_req     out registered interrupt request
//   i_flag      out interrupt enable flag
//   flg_shad_ld out one-cycle pulse: save C/Z into shadow flags
//   flg_ld_sel  out one-cycle select: restore C/Z from shadow flags
//   int_vec     out constant interrupt vector
//   busy        out high in SAVE or SERVICE
// -----------------------------------------------------------------------------
module rat_int_ctrl
   import rat_int_pkg::*;
#(
   parameter int                DEB_CYCLES = 4,
   parameter int                VEC_W      = RAT_VEC_W,
   parameter logic [VEC_W-1:0]  VECTOR     = RAT_INT_VECTOR
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             intr,
   input  logic             i_set,
   input  logic             i_clr,
   input  logic             int_ack,
   input  logic             reti,
   input  logic             reti_en,
   output logic             int_req,
   output logic             i_flag,
   output logic             flg_shad_ld,
   output logic             flg_ld_sel,
   output logic [VEC_W-1:0] int_vec,
   output logic             busy
);

   int_state_t state;
   int_state_t next_state;
   logic       edge_pulse;
   logic       pending;
   logic       take_ack;

   int_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_debounce (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (intr),
      .edge_pulse (edge_pulse)
   );

   // int_ack only means something while a request is outstanding.
   assign take_ack = (state == REQ) && int_ack;

   // NOTE: next_state gets a default before the case so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (pending && i_flag) next_state = REQ;
         REQ: begin
            if (int_ack)    next_state = SAVE;
            else if (i_clr) next_state = IDLE;
         end
         SAVE:    next_state = SERVICE;
         SERVICE: if (reti) next_state = RESTORE;
         RESTORE: next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pending     <= 1'b0;
         i_flag      <= 1'b0;
         int_req     <= 1'b0;
         flg_shad_ld <= 1'b0;
         flg_ld_sel  <= 1'b0;
      end else begin
         state <= next_state;

         // A new edge in the same cycle as the ack is kept, not lost.
         if (edge_pulse)
            pending <= 1'b1;
         else if (take_ack)
            pending <= 1'b0;

         // Entry to SAVE masks interrupts; entry to RESTORE reloads the mask
         // from reti_en while it is still qualified by the reti pulse.
         // SEI/CLI are ignored while SAVE or RESTORE is active.
         if (take_ack)
            i_flag <= 1'b0;
         else if (state == SERVICE && reti)
            i_flag <= reti_en;
         else if (state != SAVE && state != RESTORE) begin
            if (i_clr)
               i_flag <= 1'b0;
            else if (i_set)
               i_flag <= 1'b1;
         end

         // Registered outputs decoded from the state being entered.
         int_req     <= (next_state == REQ);
         flg_shad_ld <= (next_state == SAVE);
         flg_ld_sel  <= (next_state == RESTORE);
      end
   end

   assign busy    = (state == SAVE) || (state == SERVICE);
   assign int_vec = VECTOR;

endmodule : rat_int_ctrl

// File: tb/tb_rat_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rat_int_ctrl
// Directed bench for rat_int_ctrl with DEB_CYCLES = 4. Inputs change 1 ns
// after a rising edge and outputs are sampled at the same point, so each
// tick() advances exactly one clock edge.
// -----------------------------------------------------------------------------
module tb_rat_int_ctrl;
   import rat_int_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       intr, i_set, i_clr, int_ack, reti, reti_en;
   logic       int_req, i_flag, flg_shad_ld, flg_ld_sel, busy;
   logic [9:0] int_vec;

   int total = 0;
   int bad   = 0;

   rat_int_ctrl #(
      .DEB_CYCLES (4),
      .VEC_W      (10),
      .VECTOR     (10'h3FF)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .intr        (intr),
      .i_set       (i_set),
      .i_clr       (i_clr),
      .int_ack     (int_ack),
      .reti        (reti),
      .reti_en     (reti_en),
      .int_req     (int_req),
      .i_flag      (i_flag),
      .flg_shad_ld (flg_shad_ld),
      .flg_ld_sel  (flg_ld_sel),
      .int_vec     (int_vec),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n = 1'b0; intr = 0; i_set = 0; i_clr = 0;
      int_ack = 0; reti = 0; reti_en = 0;
      #12;
      check("rst_int_req", int_req, 0);
      check("rst_i_flag", i_flag, 0);
      check("rst_shad_ld", flg_shad_ld, 0);
      check("rst_ld_sel", flg_ld_sel, 0);
      check("rst_busy", busy, 0);
      check("int_vec", int_vec, 10'h3FF);
      rst_n = 1'b1;
      tick(2);

      // Basic request / ack
      i_set = 1; tick(1); i_set = 0;
      check("sei_flag", i_flag, 1);
      intr = 1;
      tick(7);
      check("req_not_yet_e7", int_req, 0);
      tick(1);
      check("req_at_e8", int_req, 1);
      int_ack = 1; tick(1); int_ack = 0;
      check("ack_shad_ld", flg_shad_ld, 1);
      check("ack_i_flag", i_flag, 0);
      check("ack_busy", busy, 1);
      check("ack_req_drop", int_req, 0);
      tick(1);
      check("shad_ld_one_cycle", flg_shad_ld, 0);
      check("service_busy", busy, 1);
      tick(3);  // intr still held: no second edge
      reti = 1; reti_en = 1; tick(1); reti = 0;
      check("retie_ld_sel", flg_ld_sel, 1);
      check("retie_flag", i_flag, 1);
      check("restore_not_busy", busy, 0);
      tick(1);
      check("ld_sel_one_cycle", flg_ld_sel, 0);
      tick(3);
      check("held_intr_one_edge", int_req, 0);
      intr = 0;
      tick(3);

      // Glitch reject: 3 sampled highs are not enough
      intr = 1; tick(3); intr = 0;
      tick(10);
      check("glitch_no_req", int_req, 0);

      // Masked request
      i_clr = 1; tick(1); i_clr = 0;
      check("cli_flag", i_flag, 0);
      intr = 1; tick(10); intr = 0;
      check("masked_no_req", int_req, 0);
      i_set = 1; tick(1); i_set = 0;
      check("masked_sei_flag", i_flag, 1);
      check("masked_req_e1", int_req, 0);
      tick(1);
      check("masked_req_e2", int_req, 1);

      // int_ack beats same-cycle i_clr in REQ
      int_ack = 1; i_clr = 1; tick(1); int_ack = 0; i_clr = 0;
      check("ack_over_cli_busy", busy, 1);
      check("ack_over_cli_shad", flg_shad_ld, 1);
      tick(1);

      // Queue an edge during SERVICE, then RETIE
      intr = 1; tick(10); intr = 0;
      check("queued_no_req", int_req, 0);
      check("queued_busy", busy, 1);
      reti = 1; reti_en = 1; tick(1); reti = 0;
      check("q_retie_ld_sel", flg_ld_sel, 1);
      check("q_retie_flag", i_flag, 1);
      check("q_req_e1", int_req, 0);
      tick(1);
      check("q_req_e2_wait", int_req, 0);
      tick(1);
      check("q_req_after_retie", int_req, 1);

      // Service again, queue another edge, then RETID
      int_ack = 1; tick(1); int_ack = 0;
      tick(1);
      intr = 1; tick(10); intr = 0;
      reti = 1; reti_en = 0; tick(1); reti = 0;
      check("retid_ld_sel", flg_ld_sel, 1);
      check("retid_flag", i_flag, 0);
      tick(3);
      check("retid_no_req", int_req, 0);

      // Stray reti outside SERVICE
      reti = 1; reti_en = 1; tick(1); reti = 0;
      check("stray_reti_sel", flg_ld_sel, 0);
      check("stray_reti_flag", i_flag, 0);

      // SEI then SEI+CLI together: CLI wins
      i_set = 1; tick(1);
      check("sei_again", i_flag, 1);
      i_clr = 1; tick(1); i_set = 0; i_clr = 0;
      check("cli_priority", i_flag, 0);
      check("req_raised", int_req, 1);
      tick(1);
      check("req_held", int_req, 1);
      i_clr = 1; tick(1); i_clr = 0;
      check("req_withdrawn", int_req, 0);

      // Stray int_ack in IDLE leaves pending intact
      int_ack = 1; tick(1); int_ack = 0;
      check("stray_ack_busy", busy, 0);
      i_set = 1; tick(1); i_set = 0;
      tick(1);
      check("pending_kept", int_req, 1);

      // Async reset mid-SERVICE with a queued edge
      int_ack = 1; tick(1); int_ack = 0;
      tick(1);
      intr = 1; tick(10); intr = 0;
      check("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_busy", busy, 0);
      check("async_rst_flag", i_flag, 0);
      check("async_rst_req", int_req, 0);
      check("async_rst_shad", flg_shad_ld, 0);
      check("async_rst_sel", flg_ld_sel, 0);
      #10 rst_n = 1'b1;
      tick(2);
      check("post_rst_busy", busy, 0);
      i_set = 1; tick(1); i_set = 0;
      tick(3);
      check("post_rst_pending_clr", int_req, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_rat_int_ctrl
